// File: rtl/matrix_key_scan.sv
// matrix_key_scan
//   Scans a 4x4 active-low keypad one column at a time, assembles a 16-bit
//   frame map per scan and runs a single-key debounce FSM once per frame.
//   Each accepted press is reported as one key_code plus a one-cycle strobe.
//
// Parameters
//   SCAN_DIV   : clock cycles each column is driven low (>= 4)
//   DEB_FRAMES : identical frames needed to accept a press or release (2..15)
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   row[3:0]  in   keypad rows, active-low, asynchronous to clk
//   col[3:0]  out  column drive, one-hot-low
//   key_code  out  code (row*4+col) of the last accepted key
//   key_valid out  one-cycle strobe, key_code valid in the same cycle
//
// Debounce FSM
//   state       | meaning
//   IDLE        | nothing held, waiting for a single-key frame
//   PRESS_DEB   | counting identical single-key frames for cand
//   HELD        | press accepted; ignore everything until all released
//   RELEASE_DEB | counting empty frames before re-arming

module matrix_key_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_FRAMES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_CNT  = 4'(DEB_FRAMES);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } state_t;

    logic [3:0]       row_m;
    logic [3:0]       row_s;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [15:0]      frame_map;
    logic [15:0]      frame_cur;
    logic             div_last;
    logic             frame_end;
    logic [4:0]       n_set;
    logic [3:0]       k_idx;
    logic             is_none;
    logic             is_single;

    state_t           state;
    state_t           state_n;
    logic [3:0]       cnt;
    logic [3:0]       cnt_n;
    logic [3:0]       cnt_inc;
    logic [3:0]       cand;
    logic [3:0]       cand_n;
    logic             fire;

    assign div_last  = (div == DIV_LAST);
    assign frame_end = div_last && (col_idx == 2'd3);
    assign cnt_inc   = cnt + 4'd1;

    // Row synchronizer resets to "all released" so no phantom press appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            col_idx <= 2'd0;
            col     <= 4'b1110;
        end else if (div_last) begin
            div     <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= {col[2:0], col[3]};
        end else begin
            div <= div + 1'b1;
        end
    end

    // Current column's bits replaced by this cycle's sample, so the frame
    // end sees column 3 without waiting another cycle.
    always_comb begin
        frame_cur = frame_map;
        for (int r = 0; r < 4; r++) begin
            frame_cur[{2'(r), col_idx}] = ~row_s[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_map <= '0;
        end else if (div_last) begin
            frame_map <= frame_cur;
        end
    end

    always_comb begin
        n_set = 5'd0;
        k_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_cur[i]) begin
                n_set = n_set + 5'd1;
                k_idx = 4'(i);
            end
        end
    end

    assign is_none   = (n_set == 5'd0);
    assign is_single = (n_set == 5'd1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        fire    = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_n  = k_idx;
                        cnt_n   = 4'd1;
                        state_n = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (is_single && (k_idx == cand)) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB_CNT) begin
                            fire    = 1'b1;
                            state_n = HELD;
                        end
                    end else begin
                        cnt_n   = 4'd0;
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        cnt_n   = 4'd1;
                        state_n = RELEASE_DEB;
                    end
                end
                RELEASE_DEB: begin
                    if (is_none) begin
                        if (cnt_inc == DEB_CNT) begin
                            cnt_n   = 4'd0;
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: begin
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_valid <= fire;
            if (fire) begin
                key_code <= cand;
            end
        end
    end

endmodule
